// File: rtl/shift_add_multiplier_pkg.sv
// Shared definitions for the shift-and-add multiplier and the control unit
// that waits on it (state encoding and default operand width).
package mult_pkg;

  localparam int MULT_WIDTH = 16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIN  = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    FIN  = ST_FIN
  } state_t;

endpackage

// File: rtl/shift_add_multiplier_if.sv
// Start/operand/result bundle between the control unit (master) and the
// multiplier datapath (slave).
interface shift_add_multiplier_if
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
);

  logic                   MULT_EN;
  logic [WIDTH-1:0]       MCAND;
  logic [WIDTH-1:0]       MPLIER;
  logic [2*WIDTH-1:0]     PRODUCT;
  logic                   BUSY;
  logic                   DONE;
  logic                   HI_NZ;

  modport master (
    output MULT_EN, MCAND, MPLIER,
    input  PRODUCT, BUSY, DONE, HI_NZ
  );

  modport slave (
    input  MULT_EN, MCAND, MPLIER,
    output PRODUCT, BUSY, DONE, HI_NZ
  );

endinterface

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned multiplier: one multiplier bit per cycle through the
// C:A:Q accumulator, WIDTH iterations, registered double-width product.
module shift_add_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic                CLK,
  input  logic                RST,
  shift_add_multiplier_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     m_q, a_q, q_q;
  logic                 c_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [2*WIDTH-1:0]   product_q;
  logic                 hi_nz_q;

  logic                 start;
  logic                 last_iter;
  logic [WIDTH:0]       sum;
  logic [WIDTH-1:0]     a_nxt, q_nxt;

  // Starts are only honoured outside RUN; a start in FIN issues back-to-back.
  assign start     = bus.MULT_EN && (state_q != RUN);
  assign last_iter = (cnt_q == CNT_W'(1));

  // C is cleared by every shift, so {C,A} here is just A zero-extended.
  always_comb begin
    sum   = {c_q, a_q};
    if (q_q[0])
      sum = {c_q, a_q} + {1'b0, m_q};
    a_nxt = sum[WIDTH:1];
    q_nxt = {sum[0], q_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.MULT_EN) state_d = RUN;
      RUN:     if (last_iter)   state_d = FIN;
      FIN:     state_d = bus.MULT_EN ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      m_q       <= '0;
      a_q       <= '0;
      q_q       <= '0;
      c_q       <= 1'b0;
      cnt_q     <= '0;
      product_q <= '0;
      hi_nz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start) begin
        m_q   <= bus.MCAND;
        q_q   <= bus.MPLIER;
        a_q   <= '0;
        c_q   <= 1'b0;
        cnt_q <= CNT_W'(WIDTH);
      end else if (state_q == RUN) begin
        c_q   <= 1'b0;
        a_q   <= a_nxt;
        q_q   <= q_nxt;
        cnt_q <= cnt_q - CNT_W'(1);
        // Publish on the final shift so PRODUCT is valid alongside DONE.
        if (last_iter) begin
          product_q <= {a_nxt, q_nxt};
          hi_nz_q   <= |a_nxt;
        end
      end
    end
  end

  assign bus.PRODUCT = product_q;
  assign bus.HI_NZ   = hi_nz_q;
  assign bus.BUSY    = (state_q == RUN);
  assign bus.DONE    = (state_q == FIN);

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier: a scoreboard of expected
// products checked on every DONE, plus per-scenario latency/handshake checks.
module tb_shift_add_multiplier;
  import mult_pkg::*;

  localparam int W = 16;

  logic CLK = 1'b0;
  logic RST;
  int   vectors = 0;
  int   miscompares = 0;
  logic [2*W:0] exp_q[$];

  always #5 CLK = ~CLK;

  shift_add_multiplier_if #(.WIDTH(W)) bus ();

  shift_add_multiplier #(.WIDTH(W)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  // Scoreboard: every DONE must match the oldest outstanding start.
  always @(negedge CLK) begin
    logic [2*W:0] e;
    if (!RST) begin
      if (bus.BUSY && bus.DONE) begin
        vectors++;
        miscompares++;
        $display("FAIL busy_done_overlap: BUSY=%b DONE=%b, required not both high", bus.BUSY, bus.DONE);
      end
      if (bus.DONE) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_done: PRODUCT=%h with no outstanding start", bus.PRODUCT);
        end else begin
          e = exp_q.pop_front();
          if ({bus.HI_NZ, bus.PRODUCT} !== e) begin
            miscompares++;
            $display("FAIL product: got HI_NZ=%b PRODUCT=%h, required HI_NZ=%b PRODUCT=%h",
                     bus.HI_NZ, bus.PRODUCT, e[2*W], e[2*W-1:0]);
          end
        end
      end
    end
  end

  // Drive a start at the current negedge; returns at the first negedge after acceptance.
  task automatic start_op(input logic [W-1:0] mc, input logic [W-1:0] mp, input bit push);
    logic [2*W-1:0] p;
    p = (2*W)'(mc) * (2*W)'(mp);
    bus.MCAND   = mc;
    bus.MPLIER  = mp;
    bus.MULT_EN = 1'b1;
    if (push) exp_q.push_back({|p[2*W-1:W], p});
    @(negedge CLK);
    bus.MULT_EN = 1'b0;
  endtask

  // Counts negedges from the current one (n=1) until DONE; stops on budget.
  task automatic wait_done(input int budget, input logic [2*W-1:0] hold,
                           output int busy_cnt, output int done_n, output int drift);
    busy_cnt = 0;
    done_n   = -1;
    drift    = 0;
    for (int n = 1; n <= budget; n++) begin
      if (bus.BUSY) begin
        busy_cnt++;
        if (bus.PRODUCT !== hold) drift++;
      end
      if (bus.DONE) begin
        done_n = n;
        break;
      end
      @(negedge CLK);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    bus.MULT_EN = 1'b0;
    bus.MCAND   = '0;
    bus.MPLIER  = '0;
    repeat (3) @(negedge CLK);
    vectors++;
    if ({bus.BUSY, bus.DONE, bus.HI_NZ, bus.PRODUCT} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: BUSY=%b DONE=%b HI_NZ=%b PRODUCT=%h, required all 0",
               bus.BUSY, bus.DONE, bus.HI_NZ, bus.PRODUCT);
    end
    RST = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_basic();
    int b, d, dr;
    start_op(16'd3, 16'd5, 1'b1);
    wait_done(40, '0, b, d, dr);
    vectors++;
    if (b !== W) begin
      miscompares++;
      $display("FAIL basic_busy_cycles: got %0d, required %0d", b, W);
    end
    vectors++;
    if (d !== W + 1) begin
      miscompares++;
      $display("FAIL basic_latency: DONE at %0d, required %0d", d, W + 1);
    end
    @(negedge CLK);
    vectors++;
    if (bus.DONE !== 1'b0 || bus.PRODUCT !== 32'h0000000F) begin
      miscompares++;
      $display("FAIL basic_hold: DONE=%b PRODUCT=%h, required DONE=0 PRODUCT=0000000f", bus.DONE, bus.PRODUCT);
    end
  endtask

  task automatic test_carry();
    int b, d, dr;
    start_op(16'hFFFF, 16'hFFFF, 1'b1);
    wait_done(40, 32'h0000000F, b, d, dr);
    vectors++;
    if (d !== W + 1) begin
      miscompares++;
      $display("FAIL carry_latency: DONE at %0d, required %0d", d, W + 1);
    end
    @(negedge CLK);
  endtask

  task automatic test_zero();
    int b, d, dr;
    start_op(16'h1234, 16'h0000, 1'b1);
    wait_done(40, 32'hFFFE0001, b, d, dr);
    vectors++;
    if (b !== W || d !== W + 1) begin
      miscompares++;
      $display("FAIL zero_mplier_latency: busy=%0d done=%0d, required busy=%0d done=%0d", b, d, W, W + 1);
    end
    @(negedge CLK);
    start_op(16'h0000, 16'hABCD, 1'b1);
    wait_done(40, 32'h0, b, d, dr);
    vectors++;
    if (d !== W + 1) begin
      miscompares++;
      $display("FAIL zero_mcand_latency: DONE at %0d, required %0d", d, W + 1);
    end
    @(negedge CLK);
  endtask

  task automatic test_ignore_in_run();
    int b, d, dr;
    start_op(16'h00FF, 16'h0101, 1'b1);
    repeat (4) @(negedge CLK);
    bus.MCAND   = 16'h1111;
    bus.MPLIER  = 16'h2222;
    bus.MULT_EN = 1'b1;
    @(negedge CLK);
    bus.MULT_EN = 1'b0;
    wait_done(40, 32'h0, b, d, dr);
    vectors++;
    if (d !== W + 1 - 6 + 1) begin
      miscompares++;
      $display("FAIL ignore_latency: DONE at %0d, required %0d", d, W + 1 - 6 + 1);
    end
    @(negedge CLK);
    vectors++;
    if (bus.BUSY !== 1'b0) begin
      miscompares++;
      $display("FAIL ignore_no_restart: BUSY=%b, required 0", bus.BUSY);
    end
  endtask

  task automatic test_reset_mid();
    int b, d, dr;
    start_op(16'd7, 16'd9, 1'b0);
    repeat (7) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    vectors++;
    if ({bus.BUSY, bus.DONE, bus.HI_NZ, bus.PRODUCT} !== '0) begin
      miscompares++;
      $display("FAIL midrun_reset: BUSY=%b DONE=%b HI_NZ=%b PRODUCT=%h, required all 0",
               bus.BUSY, bus.DONE, bus.HI_NZ, bus.PRODUCT);
    end
    RST = 1'b0;
    @(negedge CLK);
    vectors++;
    if (bus.BUSY !== 1'b0) begin
      miscompares++;
      $display("FAIL midrun_idle: BUSY=%b, required 0", bus.BUSY);
    end
    start_op(16'd2, 16'd2, 1'b1);
    wait_done(40, 32'h0, b, d, dr);
    vectors++;
    if (d !== W + 1 || dr !== 0) begin
      miscompares++;
      $display("FAIL post_reset_run: done=%0d drift=%0d, required done=%0d drift=0", d, dr, W + 1);
    end
    @(negedge CLK);
  endtask

  task automatic test_back_to_back();
    int b, d, dr;
    start_op(16'd6, 16'd7, 1'b1);
    wait_done(40, 32'h4, b, d, dr);
    vectors++;
    if (d !== W + 1) begin
      miscompares++;
      $display("FAIL b2b_first_latency: DONE at %0d, required %0d", d, W + 1);
    end
    start_op(16'h8000, 16'd2, 1'b1);
    vectors++;
    if (bus.BUSY !== 1'b1 || bus.DONE !== 1'b0 || bus.PRODUCT !== 32'd42) begin
      miscompares++;
      $display("FAIL b2b_issue: BUSY=%b DONE=%b PRODUCT=%h, required BUSY=1 DONE=0 PRODUCT=0000002a",
               bus.BUSY, bus.DONE, bus.PRODUCT);
    end
    wait_done(40, 32'd42, b, d, dr);
    vectors++;
    if (d !== W + 1 || dr !== 0) begin
      miscompares++;
      $display("FAIL b2b_second: done=%0d product_changes=%0d, required done=%0d changes=0", d, dr, W + 1);
    end
    @(negedge CLK);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_zero();
    test_ignore_in_run();
    test_reset_mid();
    test_back_to_back();
    repeat (3) @(negedge CLK);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL outstanding: %0d expected results never produced, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
